// File: rtl/polar_cfg_pkg.sv
// Shared types and legal-range constants for the polar decoder configuration controller.
package polar_cfg_pkg;

    typedef enum logic [1:0] {
        PUNCT = 2'd0,
        SHORT = 2'd1,
        REPET = 2'd2
    } rm_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOG_E = 3'd1,
        ST_LOG_K = 3'd2,
        ST_EVAL  = 3'd3,
        ST_OUT   = 3'd4
    } cfg_state_e;

    localparam logic [13:0] E_MIN = 14'd17;
    localparam logic [13:0] E_MAX = 14'd8192;
    localparam logic [9:0]  K_MIN = 10'd12;
    localparam logic [9:0]  K_MAX = 10'd1023;
    localparam int          NMIN  = 5;

endpackage

// File: rtl/polar_cfg_ctrl_clog2.sv
// Combinational ceil(log2 x) for a 15-bit operand; x of 0 or 1 yields 0.
module polar_cfg_ctrl_clog2 (
    input  logic [14:0] val_i,
    output logic [5:0]  res_o
);
    import polar_cfg_pkg::*;

    logic [14:0] dec;

    always_comb begin
        dec   = val_i - 15'd1;
        res_o = '0;
        for (int i = 0; i < 15; i++) begin
            if (dec[i]) res_o = 6'(i + 1);
        end
        if (val_i == '0) res_o = '0;
    end

endmodule

// File: rtl/polar_cfg_ctrl.sv
// Derives mother code size n / N and rate-matching mode from (E, K); one clog2
// unit is shared between the LOG_E and LOG_K cycles.
module polar_cfg_ctrl #(
    parameter int NMAX = 9,
    parameter int NMIN = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [13:0] e_i,
    input  logic [9:0]  k_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [3:0]  n_o,
    output logic [10:0] nlen_o,
    output logic [1:0]  mode_o,
    output logic        err_o,
    output logic        busy_o
);
    import polar_cfg_pkg::*;

    cfg_state_e  state_q, state_d;
    logic [13:0] e_q;
    logic [9:0]  k_q;
    logic [5:0]  ce_q, ck_q;
    logic [3:0]  n_q, n_d;
    logic [10:0] nlen_q, nlen_d;
    rm_mode_e    mode_q, mode_d;
    logic        err_q, err_d;

    logic [14:0] clog_in;
    logic [5:0]  clog_res;
    logic [19:0] e16, pow9, k16, e9, e7;
    logic [5:0]  n1, nsel;

    assign clog_in = (state_q == ST_LOG_E) ? {1'b0, e_q} : {2'b0, k_q, 3'b000};

    polar_cfg_ctrl_clog2 u_clog2 (
        .val_i (clog_in),
        .res_o (clog_res)
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cfg_valid_i) state_d = ST_LOG_E;
                ST_LOG_E: state_d = ST_LOG_K;
                ST_LOG_K: state_d = ST_EVAL;
                ST_EVAL:  state_d = ST_OUT;
                ST_OUT:   if (dec_ready_i) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Rate comparisons are kept in integers: 16E <= 9*2^ce stands in for E/2^ce <= 9/16.
    always_comb begin
        e16  = 20'(e_q) << 4;
        pow9 = 20'd9 << ce_q;
        k16  = 20'(k_q) << 4;
        e9   = 20'(e_q) * 20'd9;
        e7   = 20'(e_q) * 20'd7;

        n1 = ce_q;
        if ((e16 <= pow9) && (k16 < e9) && (ce_q != 6'd0)) n1 = ce_q - 6'd1;

        nsel = n1;
        if (ck_q < nsel)     nsel = ck_q;
        if (6'(NMAX) < nsel) nsel = 6'(NMAX);
        if (nsel < 6'(NMIN)) nsel = 6'(NMIN);

        err_d = (e_q < E_MIN) || (e_q > E_MAX) || (k_q < K_MIN)
              || ({1'b0, k_q} > {1'b0, K_MAX}) || ({4'd0, k_q} > e_q);

        n_d    = err_d ? 4'd5 : 4'(nsel);
        nlen_d = 11'd1 << n_d;

        if (err_d)                   mode_d = PUNCT;
        else if (e_q >= 14'(nlen_d)) mode_d = REPET;
        else if (k16 <= e7)          mode_d = PUNCT;
        else                         mode_d = SHORT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            e_q     <= '0;
            k_q     <= '0;
            ce_q    <= '0;
            ck_q    <= '0;
            n_q     <= '0;
            nlen_q  <= '0;
            mode_q  <= PUNCT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!flush_i) begin
                if (state_q == ST_IDLE && cfg_valid_i) begin
                    e_q <= e_i;
                    k_q <= k_i;
                end
                if (state_q == ST_LOG_E) ce_q <= clog_res;
                if (state_q == ST_LOG_K) ck_q <= clog_res;
                if (state_q == ST_EVAL) begin
                    n_q    <= n_d;
                    nlen_q <= nlen_d;
                    mode_q <= mode_d;
                    err_q  <= err_d;
                end
            end
        end
    end

    assign cfg_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign dec_valid_o = (state_q == ST_OUT);
    assign n_o         = n_q;
    assign nlen_o      = nlen_q;
    assign mode_o      = mode_q;
    assign err_o       = err_q;

endmodule
